// File: rtl/nf_ahb_pkg.sv
// Shared AHB encodings and default-slave state type for the data-phase mux.
package nf_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

endpackage

// File: rtl/nf_ahb_def_slave.sv
// Default slave: answers unmapped NONSEQ/SEQ transfers with the two-cycle ERROR response.
module nf_ahb_def_slave
    import nf_ahb_pkg::*;
(
    input  logic       i_hclk,
    input  logic       i_hresetn,
    input  logic       i_hready,
    input  logic [1:0] i_htrans,
    input  logic       i_unmapped,
    output logic       o_ds_active,
    output logic       o_ds_hready,
    output logic       o_ds_hresp
);

    ds_state_t r_state;
    ds_state_t w_state_nxt;
    logic      w_err_start;

    assign w_err_start = i_hready && i_unmapped &&
                         ((i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ));

    // State register
    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            r_state <= DS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and response outputs; ERR2 can chain straight into a new ERR1
    always_comb begin
        w_state_nxt = r_state;
        o_ds_active = 1'b0;
        o_ds_hready = 1'b1;
        o_ds_hresp  = HRESP_OKAY;
        case (r_state)
            DS_IDLE: begin
                if (w_err_start) begin
                    w_state_nxt = DS_ERR1;
                end else begin
                    w_state_nxt = DS_IDLE;
                end
            end
            DS_ERR1: begin
                o_ds_active = 1'b1;
                o_ds_hready = 1'b0;
                o_ds_hresp  = HRESP_ERROR;
                w_state_nxt = DS_ERR2;
            end
            DS_ERR2: begin
                o_ds_active = 1'b1;
                o_ds_hready = 1'b1;
                o_ds_hresp  = HRESP_ERROR;
                if (w_err_start) begin
                    w_state_nxt = DS_ERR1;
                end else begin
                    w_state_nxt = DS_IDLE;
                end
            end
            default: begin
                w_state_nxt = DS_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/nf_ahb_dp_mux.sv
// AHB data-phase response multiplexer: registers the address-phase select and
// routes the selected slave's response, falling back to the built-in default slave.
module nf_ahb_dp_mux
    import nf_ahb_pkg::*;
#(
    parameter int SLAVE_C = 3
) (
    input  logic               i_hclk,
    input  logic               i_hresetn,
    input  logic [SLAVE_C-1:0] i_hsel,
    input  logic [1:0]         i_htrans,
    input  logic [31:0]        i_hrdata_s [SLAVE_C],
    input  logic [SLAVE_C-1:0] i_hresp_s,
    input  logic [SLAVE_C-1:0] i_hreadyout_s,
    output logic [31:0]        o_hrdata,
    output logic               o_hresp,
    output logic               o_hready
);

    logic [SLAVE_C-1:0] r_sel_dp;
    logic [SLAVE_C-1:0] w_hsel_pri;
    logic               w_found;
    logic [31:0]        w_rdata_mux;
    logic               w_resp_mux;
    logic               w_rdy_mux;
    logic               w_unmapped;
    logic               w_ds_active;
    logic               w_ds_hready;
    logic               w_ds_hresp;

    assign w_unmapped = (i_hsel == {SLAVE_C{1'b0}});

    // Lowest-index priority keeps the data-phase select one-hot or zero
    always_comb begin
        w_hsel_pri = {SLAVE_C{1'b0}};
        w_found    = 1'b0;
        for (int i = 0; i < SLAVE_C; i++) begin
            w_hsel_pri[i] = i_hsel[i] & ~w_found;
            w_found       = w_found | i_hsel[i];
        end
    end

    // Data-phase select; an unmapped sample loads zero so the default slave owns the bus
    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            r_sel_dp <= {SLAVE_C{1'b0}};
        end else if (o_hready) begin
            r_sel_dp <= w_hsel_pri;
        end else begin
            r_sel_dp <= r_sel_dp;
        end
    end

    nf_ahb_def_slave u_def_slave (
        .i_hclk      (i_hclk),
        .i_hresetn   (i_hresetn),
        .i_hready    (o_hready),
        .i_htrans    (i_htrans),
        .i_unmapped  (w_unmapped),
        .o_ds_active (w_ds_active),
        .o_ds_hready (w_ds_hready),
        .o_ds_hresp  (w_ds_hresp)
    );

    // AND-OR mux: unselected slaves are masked, so their data can never leak through
    always_comb begin
        w_rdata_mux = 32'h0000_0000;
        for (int i = 0; i < SLAVE_C; i++) begin
            w_rdata_mux = w_rdata_mux | ({32{r_sel_dp[i]}} & i_hrdata_s[i]);
        end
        w_resp_mux = |(r_sel_dp & i_hresp_s);
        w_rdy_mux  = &(~r_sel_dp | i_hreadyout_s);
    end

    // Final response: default slave overrides, nothing selected gives zero-wait OKAY
    always_comb begin
        if (w_ds_active) begin
            o_hrdata = 32'h0000_0000;
            o_hresp  = w_ds_hresp;
            o_hready = w_ds_hready;
        end else begin
            o_hrdata = w_rdata_mux;
            o_hresp  = w_resp_mux;
            o_hready = w_rdy_mux;
        end
    end

endmodule

// File: tb/tb_nf_ahb_dp_mux.sv
// Self-checking bench for nf_ahb_dp_mux with three slaves: transaction-level model
// compared every cycle, plus directed literal checks.
module tb_nf_ahb_dp_mux;

    logic        clk;
    logic        rst_n;
    logic [2:0]  hsel;
    logic [1:0]  htrans;
    logic [31:0] hrdata_s [3];
    logic [2:0]  hresp_s;
    logic [2:0]  hreadyout_s;
    logic [31:0] hrdata;
    logic        hresp;
    logic        hready;

    int n_tests;
    int n_fail;

    nf_ahb_dp_mux #(.SLAVE_C(3)) dut (
        .i_hclk        (clk),
        .i_hresetn     (rst_n),
        .i_hsel        (hsel),
        .i_htrans      (htrans),
        .i_hrdata_s    (hrdata_s),
        .i_hresp_s     (hresp_s),
        .i_hreadyout_s (hreadyout_s),
        .o_hrdata      (hrdata),
        .o_hresp       (hresp),
        .o_hready      (hready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the transfer currently in its data phase.
    // kind 0 = nothing / zero-wait OKAY, 1 = slave m_idx, 2 = error response (m_errcyc 0 or 1)
    int m_kind;
    int m_idx;
    int m_errcyc;

    function automatic logic exp_hready();
        if (m_kind == 1) return hreadyout_s[m_idx];
        if (m_kind == 2) return (m_errcyc == 1);
        return 1'b1;
    endfunction

    function automatic logic exp_hresp();
        if (m_kind == 1) return hresp_s[m_idx];
        if (m_kind == 2) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_hrdata();
        if (m_kind == 1) return hrdata_s[m_idx];
        return 32'h0000_0000;
    endfunction

    function automatic int lowest_set(input logic [2:0] v);
        for (int i = 0; i < 3; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Advance the model one clock: a completed data phase lets the next address phase in
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_kind   <= 0;
            m_idx    <= 0;
            m_errcyc <= 0;
        end else if (exp_hready()) begin
            if (hsel != 3'b000) begin
                m_kind   <= 1;
                m_idx    <= lowest_set(hsel);
                m_errcyc <= 0;
            end else if (htrans == 2'b10 || htrans == 2'b11) begin
                m_kind   <= 2;
                m_errcyc <= 0;
            end else begin
                m_kind   <= 0;
            end
        end else if (m_kind == 2) begin
            m_errcyc <= 1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        n_tests = n_tests + 1;
        if (hready !== exp_hready() || hresp !== exp_hresp() || hrdata !== exp_hrdata()) begin
            n_fail = n_fail + 1;
            $display("FAIL model t=%0t: got rdy=%b resp=%b data=%h, need rdy=%b resp=%b data=%h",
                     $time, hready, hresp, hrdata, exp_hready(), exp_hresp(), exp_hrdata());
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests = n_tests + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, need %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_bus();
        hsel   = 3'b000;
        htrans = 2'b00;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        hsel        = 3'b000;
        htrans      = 2'b00;
        hresp_s     = 3'b000;
        hreadyout_s = 3'b111;
        hrdata_s[0] = 32'h1111_0000;
        hrdata_s[1] = 32'h2222_0001;
        hrdata_s[2] = 32'h3333_0002;
        tick();
        check("reset_hready", {31'd0, hready}, 32'd1);
        check("reset_hrdata", hrdata, 32'h0000_0000);
        rst_n = 1'b1;
        tick();

        // 1: reset in the middle of a stalled slave1 data phase
        hsel = 3'b010; htrans = 2'b10; hreadyout_s[1] = 1'b0;
        tick();
        idle_bus();
        check("t1_stalled", {31'd0, hready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("t1_rst_hready", {31'd0, hready}, 32'd1);
        check("t1_rst_hresp", {31'd0, hresp}, 32'd0);
        check("t1_rst_hrdata", hrdata, 32'h0000_0000);
        tick();
        rst_n = 1'b1;
        hreadyout_s[1] = 1'b1;
        tick();

        // 2: simple read from slave0
        hsel = 3'b001; htrans = 2'b10; hrdata_s[0] = 32'hDEAD_BEEF;
        tick();
        idle_bus();
        check("t2_hrdata", hrdata, 32'hDEAD_BEEF);
        check("t2_hresp", {31'd0, hresp}, 32'd0);
        check("t2_hready", {31'd0, hready}, 32'd1);
        tick();

        // 3: slave2 inserts two wait states while slave1 transfer is queued
        hsel = 3'b100; htrans = 2'b10; hreadyout_s[2] = 1'b0;
        tick();
        hsel = 3'b010; htrans = 2'b10;
        check("t3_wait1", {31'd0, hready}, 32'd0);
        tick();
        check("t3_wait2", {31'd0, hready}, 32'd0);
        check("t3_wait2_data", hrdata, 32'h3333_0002);
        tick();
        hreadyout_s[2] = 1'b1;
        #1;
        check("t3_done", {31'd0, hready}, 32'd1);
        tick();
        idle_bus();
        check("t3_queued_data", hrdata, 32'h2222_0001);
        tick();

        // 4: unmapped NONSEQ, then IDLE
        hsel = 3'b000; htrans = 2'b10;
        tick();
        idle_bus();
        check("t4_err1_hready", {31'd0, hready}, 32'd0);
        check("t4_err1_hresp", {31'd0, hresp}, 32'd1);
        check("t4_err1_hrdata", hrdata, 32'h0000_0000);
        tick();
        check("t4_err2_hready", {31'd0, hready}, 32'd1);
        check("t4_err2_hresp", {31'd0, hresp}, 32'd1);
        tick();
        check("t4_okay_hready", {31'd0, hready}, 32'd1);
        check("t4_okay_hresp", {31'd0, hresp}, 32'd0);

        // 5: back-to-back unmapped SEQ, then IDLE with nothing selected
        hsel = 3'b000; htrans = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t5_chain_hready", {31'd0, hready}, (k % 2 == 0) ? 32'd0 : 32'd1);
            check("t5_chain_hresp", {31'd0, hresp}, 32'd1);
        end
        idle_bus();
        tick();
        check("t5_idle_hready", {31'd0, hready}, 32'd1);
        check("t5_idle_hresp", {31'd0, hresp}, 32'd0);

        // 6: multi-hot select resolves to slave1; slave2 signals must not leak
        hsel = 3'b110; htrans = 2'b10;
        hrdata_s[1] = 32'hA5A5_0101; hrdata_s[2] = 32'h5A5A_0202;
        hresp_s[2] = 1'b1; hreadyout_s[2] = 1'b0;
        tick();
        idle_bus();
        check("t6_hrdata", hrdata, 32'hA5A5_0101);
        check("t6_hresp", {31'd0, hresp}, 32'd0);
        check("t6_hready", {31'd0, hready}, 32'd1);
        hresp_s[2] = 1'b0; hreadyout_s[2] = 1'b1;
        tick();

        // IDLE/BUSY to a mapped slave still selects it
        hsel = 3'b100; htrans = 2'b01;
        tick();
        idle_bus();
        check("busy_mapped_hrdata", hrdata, 32'h5A5A_0202);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
